// File: rtl/chan_en_gen_pkg.sv
// Package chan_en_pkg: shared types and helpers for the chan_en_gen slice.
//   div_t       : divide-ratio type at the default width DIV_W (modules use
//                 their own CW parameter for the actual datapath width)
//   chan_cfg_t  : one channel's programmable configuration (ratio + phase mode)
//   chan_idx_valid(idx, nch) : 1 when idx addresses an existing channel
package chan_en_pkg;

  localparam int DIV_W = 8;

  typedef logic [DIV_W-1:0] div_t;

  typedef struct packed {
    div_t div;
    logic inv;
  } chan_cfg_t;

  function automatic logic chan_idx_valid(input logic [31:0] idx, input logic [31:0] nch);
    return idx < nch;
  endfunction

endpackage

// File: rtl/chan_en_gen_ctr.sv
// chan_en_ctr: one channel of the enable generator (counter, shadow config,
// pulse and phase outputs).
//   clk, rst  : clock, synchronous active-high reset
//   on        : channel run enable
//   sync      : realign request (tied low when the sync feature is absent)
//   wr        : shadow write strobe (already qualified by the top)
//   wr_div    : new divide ratio D, period D+1 cycles
//   wr_inv    : 1 = pulse at mid-period (cnt == D>>1)
//   pend      : shadow holds a config not yet applied
//   en        : registered one-cycle enable pulse
//   phase     : registered level, toggles with every en pulse
module chan_en_ctr
  import chan_en_pkg::*;
#(
  parameter int CW      = 8,
  parameter int DIV_RST = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          on,
  input  logic          sync,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  input  logic          wr_inv,
  output logic          pend,
  output logic          en,
  output logic          phase
);

  logic [CW-1:0] cnt_reg, div_reg, sdiv_reg;
  logic          inv_reg, sinv_reg, pend_reg, en_reg, phase_reg;

  logic [CW-1:0] match;
  logic          hit, wrap, restart, apply;

  always_comb begin
    match   = inv_reg ? (div_reg >> 1) : div_reg;
    hit     = (cnt_reg == match);
    wrap    = (cnt_reg == div_reg);
    // Off or realigned: the count restarts from 0, so the shadow can land now.
    restart = !on || sync;
    apply   = pend_reg && (restart || wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      div_reg   <= CW'(DIV_RST);
      inv_reg   <= 1'b0;
      sdiv_reg  <= '0;
      sinv_reg  <= 1'b0;
      pend_reg  <= 1'b0;
      en_reg    <= 1'b0;
      phase_reg <= 1'b0;
    end else begin
      if (restart) begin
        cnt_reg   <= '0;
        en_reg    <= 1'b0;
        phase_reg <= 1'b0;
      end else begin
        // Pulse decision uses the ratio in force this period, even if the
        // shadow is loaded on this same wrap.
        en_reg    <= hit;
        phase_reg <= phase_reg ^ hit;
        cnt_reg   <= wrap ? '0 : cnt_reg + 1'b1;
      end
      if (apply) begin
        div_reg  <= sdiv_reg;
        inv_reg  <= sinv_reg;
        pend_reg <= 1'b0;
      end
      // The top only raises wr while pend is low, so this never races apply.
      if (wr) begin
        sdiv_reg <= wr_div;
        sinv_reg <= wr_inv;
        pend_reg <= 1'b1;
      end
    end
  end

  assign pend  = pend_reg;
  assign en    = en_reg;
  assign phase = phase_reg;

endmodule

// File: rtl/chan_en_gen.sv
// chan_en_gen: multi-channel clock-enable generator on one shared clock.
// Each channel pulses en[i] every D+1 cycles and toggles phase[i] with it;
// D and the mid-period option are programmed through a valid/ready port and
// take effect at the channel's next wrap (or next cycle when it is off).
//   clk, rst         : clock, synchronous active-high reset
//   cfg_valid/ready  : config handshake; ready = !pend of the addressed channel,
//                      always 1 for a channel index that does not exist
//   cfg_chan         : target channel
//   cfg_div, cfg_inv : new divide ratio and mid-period pulse select
//   chan_on          : per-channel run enable
//   en, phase        : per-channel registered pulse and phase level
//   sync             : only when CHAN_EN_GEN_SYNC_EN is defined; realigns all
//                      running channels (count to 0, en low, phase cleared)
module chan_en_gen
  import chan_en_pkg::*;
#(
  parameter  int NCH     = 2,
  parameter  int CW      = 8,
  parameter  int DIV_RST = 0,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_chan,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_inv,
  input  logic [NCH-1:0] chan_on,
  output logic [NCH-1:0] en,
  output logic [NCH-1:0] phase
`ifdef CHAN_EN_GEN_SYNC_EN
  ,
  input  logic           sync
`endif
);

  logic [NCH-1:0] sel, pend, wr;
  logic           chan_ok, sync_w;

`ifdef CHAN_EN_GEN_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  // Out-of-range requests see ready=1 and decode to no channel, so they drop.
  assign chan_ok   = chan_idx_valid(32'(cfg_chan), 32'(NCH));
  assign cfg_ready = !chan_ok || !(|(sel & pend));

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign sel[gi] = (cfg_chan == CHW'(gi));
      assign wr[gi]  = cfg_valid && cfg_ready && chan_ok && sel[gi];

      chan_en_ctr #(
        .CW      (CW),
        .DIV_RST (DIV_RST)
      ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .on     (chan_on[gi]),
        .sync   (sync_w),
        .wr     (wr[gi]),
        .wr_div (cfg_div),
        .wr_inv (cfg_inv),
        .pend   (pend[gi]),
        .en     (en[gi]),
        .phase  (phase[gi])
      );
    end
  endgenerate

endmodule
